// File: rtl/core_pkg.sv
// Shared types and constants for the v4 core's memory access path.
// Pure declarations: no logic, no latency.
// No flow control of its own.
package core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LD_REQ = 2'd1,
    LD_WB  = 2'd2,
    ST_REQ = 2'd3
  } mem_state_t;

  localparam int DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter that flags the last permitted cycle of a RAM request.
// Latency: expired is combinational from the registered count.
// No backpressure; clear wins over enable, and the count never wraps.
module wait_timer
  import core_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clock,
  input  logic nReset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] EXP_VAL = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CNT_W-1:0] r_cnt;

  // Count waiting cycles, restarting on clear and holding at the ceiling.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // A zero TIMEOUT means requests may wait forever.
  assign expired = (TIMEOUT > 0) && (r_cnt == EXP_VAL);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences data-RAM loads/stores, freezing the PC and gating regfile writes.
// Latency: ALU ops 1 cycle, stores >= 2 cycles, loads >= 3 cycles.
// Stalls on missing mem_ack; aborts with an err pulse after TIMEOUT waiting cycles.
module mem_access_ctrl
  import core_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_MEM_TIMEOUT
) (
  input  logic clock,
  input  logic nReset,
  input  logic ramR,
  input  logic ramW,
  input  logic regw,
  input  logic writesel,
  input  logic mem_ack,
  output logic mem_req,
  output logic mem_we,
  output logic incr_en,
  output logic regw_en,
  output logic busy,
  output logic err
);

  mem_state_t r_state;
  mem_state_t w_state_nxt;
  logic       r_mem_req;
  logic       w_mem_req_nxt;
  logic       r_mem_we;
  logic       w_mem_we_nxt;
  logic       r_err;
  logic       w_err_nxt;
  logic       w_tmr_clear;
  logic       w_tmr_en;
  logic       w_expired;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clock   (clock),
    .nReset  (nReset),
    .clear   (w_tmr_clear),
    .enable  (w_tmr_en),
    .expired (w_expired)
  );

  // State and registered RAM-facing outputs.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      r_state   <= IDLE;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_req <= w_mem_req_nxt;
      r_mem_we  <= w_mem_we_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next state, next registered outputs and the combinational stall/writeback gates.
  always_comb begin
    w_state_nxt   = r_state;
    w_mem_req_nxt = r_mem_req;
    w_mem_we_nxt  = r_mem_we;
    w_err_nxt     = 1'b0;
    incr_en       = 1'b0;
    regw_en       = 1'b0;
    w_tmr_clear   = 1'b0;
    w_tmr_en      = 1'b0;
    case (r_state)
      IDLE: begin
        // Decoder inputs are only trusted here; mem_ack is ignored.
        w_tmr_clear = 1'b1;
        if (ramR && ramW) begin
          w_err_nxt = 1'b1;
          incr_en   = 1'b1;
        end else if (ramR) begin
          w_state_nxt   = LD_REQ;
          w_mem_req_nxt = 1'b1;
          w_mem_we_nxt  = 1'b0;
        end else if (ramW) begin
          w_state_nxt   = ST_REQ;
          w_mem_req_nxt = 1'b1;
          w_mem_we_nxt  = 1'b1;
        end else begin
          incr_en = 1'b1;
          regw_en = regw;
        end
      end
      LD_REQ: begin
        // An ack on the final permitted cycle beats the abort.
        if (mem_ack) begin
          w_state_nxt   = LD_WB;
          w_mem_req_nxt = 1'b0;
        end else if (w_expired) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_err_nxt     = 1'b1;
          incr_en       = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      LD_WB: begin
        // Read data is written back exactly once, here.
        regw_en     = regw & writesel;
        incr_en     = 1'b1;
        w_state_nxt = IDLE;
      end
      ST_REQ: begin
        if (mem_ack) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          incr_en       = 1'b1;
        end else if (w_expired) begin
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_err_nxt     = 1'b1;
          incr_en       = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
        w_mem_we_nxt  = 1'b0;
      end
    endcase
  end

  assign mem_req = r_mem_req;
  assign mem_we  = r_mem_we;
  assign err     = r_err;
  assign busy    = (r_state != IDLE);

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle sequencer for data-RAM loads and stores in the v4 single-issue RISC-V core.
- Sits between the instruction decoder and the data RAM/register file.
  - Consumes the decoder's ramR, ramW, regw and writesel.
  - Stalls PC increment while a RAM access is outstanding.
  - Drives a req/ack handshake to the RAM.
  - Gates register-file write-enable so loaded data is written exactly once.
- Non-memory instructions pass through with zero added latency.

Parameters:
- TIMEOUT, 16: max cycles mem_req may stay high without mem_ack before the access is aborted; 0 disables the timeout.
- CNT_W, $clog2(TIMEOUT+1) (minimum 1): width of the wait counter; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge
- nReset  in  1  asynchronous active-low reset
- ramR  in  1  decoder: current instruction is a load
- ramW  in  1  decoder: current instruction is a store
- regw  in  1  decoder: instruction writes rd
- writesel  in  1  decoder: 1 = writeback from RAM, 0 = from ALU
- mem_ack  in  1  RAM: access complete this cycle (read data valid for loads)
- mem_req  out  1  registered request to RAM
- mem_we  out  1  registered write strobe, qualifies mem_req
- incr_en  out  1  PC may advance this cycle
- regw_en  out  1  gated register-file write enable
- busy  out  1  controller not in IDLE
- err  out  1  one-cycle pulse on illegal decode or timeout

Behaviour:
- Reset (asynchronous, immediate, also mid-access):
  - state = IDLE; mem_req = 0; mem_we = 0; err = 0; wait counter = 0.
  - incr_en and regw_en take their IDLE combinational values.
- States: IDLE, LD_REQ, LD_WB, ST_REQ.
- mem_req, mem_we and err are registered. incr_en, regw_en and busy are combinational from state and inputs.
- IDLE:
  - ramR=0, ramW=0: incr_en=1, regw_en=regw. No state change (ALU/immediate instructions, 1 cycle).
  - ramR=1, ramW=0: incr_en=0, regw_en=0. Next state LD_REQ, mem_req<=1, mem_we<=0, counter<=0.
  - ramW=1, ramR=0: incr_en=0, regw_en=0. Next state ST_REQ, mem_req<=1, mem_we<=1, counter<=0.
  - ramR=1, ramW=1 (illegal): err<=1 for one cycle; no access; incr_en=1, regw_en=0; stay IDLE.
  - mem_ack is ignored.
- LD_REQ:
  - incr_en=0, regw_en=0.
  - mem_ack=1: mem_req<=0, next LD_WB.
  - Otherwise counter increments.
- LD_WB:
  - regw_en = regw & writesel; incr_en=1.
  - Next IDLE.
  - Minimum load latency 3 cycles (ack in the first LD_REQ cycle).
- ST_REQ:
  - regw_en=0.
  - mem_ack=1: incr_en=1 that same cycle, mem_req<=0, mem_we<=0, next IDLE. Minimum store latency 2 cycles.
  - Otherwise incr_en=0, counter increments.
- Timeout (TIMEOUT>0):
  - In LD_REQ or ST_REQ, counter==TIMEOUT-1 and mem_ack=0: abort.
  - Abort: err<=1, mem_req<=0, mem_we<=0, incr_en=1, regw_en=0, next IDLE.
  - A mem_ack arriving in the same cycle as the timeout takes priority over the abort.
  - Late acks after an abort land in IDLE and are ignored.
- Input sampling: ramR/ramW/regw are sampled only in IDLE. The decoder inputs stay stable during a stall because the PC is frozen.
- busy = (state != IDLE).
- Counter saturates; it never wraps.

Decomposition:
- Shared package core_pkg:
  - typedef enum logic [1:0] mem_state_t {IDLE, LD_REQ, LD_WB, ST_REQ}.
  - Constant DEFAULT_MEM_TIMEOUT = 16.
- One natural sub-module: wait_timer.
  - Ports: clear, enable, expired.
  - Parameterised by TIMEOUT; owns the saturating counter.

Test Plan:
- ALU op: ramR=0, ramW=0, regw=1 for 4 cycles -> incr_en=1, regw_en=1 every cycle, busy=0, mem_req never asserted.
- Load, ack after 2 cycles: ramR=1, regw=1, writesel=1 at cycle 0 -> mem_req=1 in cycles 1–2, mem_ack at cycle 2, regw_en=1 and incr_en=1 only in cycle 3, IDLE at cycle 4.
- Store, immediate ack: ramW=1 at cycle 0 -> cycle 1 mem_req=1, mem_we=1, mem_ack=1, incr_en=1, regw_en=0; cycle 2 IDLE with mem_req=0.
- Timeout, TIMEOUT=4: load with no ack -> mem_req high for cycles 1–4, err=1 in cycle 5, mem_req=0, incr_en=1 in cycle 4, regw_en never 1; a late ack at cycle 7 causes no effect.
- Illegal decode: ramR=1, ramW=1 -> err pulse next cycle, mem_req stays 0, incr_en=1, state stays IDLE.
- Reset mid-load: nReset=0 asynchronously during LD_REQ -> mem_req=0, busy=0 before the next clock edge; after release, an ALU op proceeds normally.
